// File: rtl/layers_pkg.sv
`default_nettype none
// ============================================================================
// Module      : layers_pkg
// Description : Shared types, constants and the round-robin helper used by
//               the layer frame arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package layers_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FORWARD = 2'd1,
        ST_TERM    = 2'd2,
        ST_DRAIN   = 2'd3
    } arb_state_t;

    // Byte emitted to close a frame whose source stalled.
    localparam logic [7:0] FRAME_TERM_BYTE = 8'hFF;

    // Widest supported request vector; narrower vectors are zero-padded.
    localparam int MAX_LAYERS = 8;

    // First requester after 'last' in rotation. Unused request bits are zero,
    // so rotating over all eight slots gives the same order as rotating over
    // only the populated ones. 'last' itself has the lowest priority.
    function automatic logic [2:0] rr_next(input logic [7:0] req, input logic [2:0] last);
        logic [2:0] idx;
        rr_next = last;
        for (int i = MAX_LAYERS; i >= 1; i--) begin
            idx = last + 3'(i);
            if (req[idx]) begin
                rr_next = idx;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : axis_out_reg
// Description : One-deep registered AXI-Stream output stage. The owner loads
//               a beat only while free_o is high; the beat then holds stable
//               until the sink takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_out_reg (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic [7:0] dest_i,
    input  logic       last_i,
    input  logic       ready_i,
    output logic       free_o,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic [7:0] dest_o,
    output logic       last_o
);

    logic       valid_q;
    logic [7:0] data_q;
    logic [7:0] dest_q;
    logic       last_q;

    // Free when empty, or when the current beat leaves on this edge.
    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign dest_o  = dest_q;
    assign last_o  = last_q;

    // Capture a new beat on load; otherwise retire the held beat on ready.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            dest_q  <= 8'h00;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            dest_q  <= dest_i;
            last_q  <= last_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/layers_frames_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : layers_frames_arbiter
// Description : Round-robin frame arbiter merging per-layer byte streams into
//               one output stream. A grant is held for a whole frame; a
//               stalled source is cut off with a 0xFF terminator and the rest
//               of its frame is drained.
// Revision    : 1.0 - initial release
// ============================================================================
module layers_frames_arbiter
    import layers_pkg::*;
#(
    parameter int LAYERS    = 3,
    parameter int TIMEOUT_W = 16
) (
    input  logic                  clk_core,
    input  logic                  clk_core_reset,
    input  logic [LAYERS*8-1:0]   s_axis_tdata,
    input  logic [LAYERS*8-1:0]   s_axis_tdest,
    input  logic [LAYERS-1:0]     s_axis_tlast,
    input  logic [LAYERS-1:0]     s_axis_tvalid,
    output logic [LAYERS-1:0]     s_axis_tready,
    output logic [7:0]            m_axis_tdata,
    output logic [7:0]            m_axis_tdest,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic [LAYERS-1:0]     cfg_layer_mask,
    input  logic [TIMEOUT_W-1:0]  cfg_stall_timeout,
    output logic                  status_grant_active,
    output logic [2:0]            status_grant_index,
    output logic                  stat_frame_done,
    output logic                  stat_timeout
);

    arb_state_t           state_q, state_d;
    logic [2:0]           grant_q, grant_d;
    logic [2:0]           last_grant_q, last_grant_d;
    logic [TIMEOUT_W-1:0] stall_q, stall_d;
    logic [7:0]           tdest_q, tdest_d;

    logic [7:0]        req;
    logic [2:0]        rr_pick;
    logic [LAYERS-1:0] grant_oh;
    logic [7:0]        sel_data, sel_dest, pick_dest;
    logic              sel_valid, sel_last, sel_mask;
    logic              out_free, out_load, out_last;
    logic [7:0]        out_data, out_dest;
    logic              fwd_accept, stall_hit, timeout_fire;

    assign req     = 8'(s_axis_tvalid & ~cfg_layer_mask);
    assign rr_pick = rr_next(req, last_grant_q);

    // Mux the granted layer's inputs, and the tdest of the layer about to win.
    always_comb begin
        grant_oh  = '0;
        sel_data  = 8'h00;
        sel_dest  = 8'h00;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_mask  = 1'b0;
        pick_dest = 8'h00;
        for (int i = 0; i < LAYERS; i++) begin
            if (grant_q == 3'(i)) begin
                grant_oh[i] = 1'b1;
                sel_data    = s_axis_tdata[i*8 +: 8];
                sel_dest    = s_axis_tdest[i*8 +: 8];
                sel_valid   = s_axis_tvalid[i];
                sel_last    = s_axis_tlast[i];
                sel_mask    = cfg_layer_mask[i];
            end
            if (rr_pick == 3'(i)) begin
                pick_dest = s_axis_tdest[i*8 +: 8];
            end
        end
    end

    // A byte is taken only while forwarding into a free output register.
    assign fwd_accept   = (state_q == ST_FORWARD) && sel_valid && out_free && !clk_core_reset;
    assign stall_hit    = (cfg_stall_timeout != '0) && (stall_q == cfg_stall_timeout);
    // Any byte accepted on the match cycle (tlast included) ends the stall.
    assign timeout_fire = (state_q == ST_FORWARD) && stall_hit && !fwd_accept && !clk_core_reset;

    // State register with grant bookkeeping and stall counter.
    always_ff @(posedge clk_core) begin
        if (clk_core_reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 3'd0;
            last_grant_q <= 3'(LAYERS - 1);
            stall_q      <= '0;
            tdest_q      <= 8'h00;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            stall_q      <= stall_d;
            tdest_q      <= tdest_d;
        end
    end

    // Next-state logic: arbitration, frame tracking, stall detection.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        stall_d      = stall_q;
        tdest_d      = tdest_q;
        case (state_q)
            ST_IDLE: begin
                stall_d = '0;
                if (req != 8'h00) begin
                    grant_d      = rr_pick;
                    last_grant_d = rr_pick;
                    tdest_d      = pick_dest;
                    state_d      = ST_FORWARD;
                end
            end
            ST_FORWARD: begin
                if (fwd_accept) begin
                    stall_d = '0;
                    tdest_d = sel_dest;
                    if (sel_last) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (!sel_valid && (stall_q != '1)) begin
                        stall_d = stall_q + 1'b1;
                    end
                    if (timeout_fire) begin
                        state_d = ST_TERM;
                    end
                end
            end
            ST_TERM: begin
                if (out_free) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (sel_mask) begin
                    state_d = ST_IDLE;
                end else if (sel_valid && sel_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: source readies, output-register load and event pulses.
    always_comb begin
        s_axis_tready   = '0;
        out_load        = 1'b0;
        out_data        = 8'h00;
        out_dest        = 8'h00;
        out_last        = 1'b0;
        stat_frame_done = 1'b0;
        stat_timeout    = 1'b0;
        if (!clk_core_reset) begin
            case (state_q)
                ST_FORWARD: begin
                    s_axis_tready   = grant_oh & {LAYERS{out_free}};
                    out_load        = fwd_accept;
                    out_data        = sel_data;
                    out_dest        = sel_dest;
                    out_last        = sel_last;
                    stat_frame_done = fwd_accept && sel_last;
                    stat_timeout    = timeout_fire;
                end
                ST_TERM: begin
                    out_load        = out_free;
                    out_data        = FRAME_TERM_BYTE;
                    out_dest        = tdest_q;
                    out_last        = 1'b1;
                    stat_frame_done = out_free;
                end
                ST_DRAIN: begin
                    s_axis_tready = grant_oh & {LAYERS{!sel_mask}};
                end
                default: begin
                    s_axis_tready = '0;
                end
            endcase
        end
    end

    assign status_grant_active = (state_q != ST_IDLE);
    assign status_grant_index  = grant_q;

    axis_out_reg u_out (
        .clk_i   (clk_core),
        .rst_i   (clk_core_reset),
        .load_i  (out_load),
        .data_i  (out_data),
        .dest_i  (out_dest),
        .last_i  (out_last),
        .ready_i (m_axis_tready),
        .free_o  (out_free),
        .valid_o (m_axis_tvalid),
        .data_o  (m_axis_tdata),
        .dest_o  (m_axis_tdest),
        .last_o  (m_axis_tlast)
    );

endmodule
`default_nettype wire

// File: tb/tb_layers_frames_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_layers_frames_arbiter
// Description : Scoreboard bench for layers_frames_arbiter. Per-layer source
//               queues feed the inputs; expected output beats are queued by
//               the test sequence and checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layers_frames_arbiter;

    localparam int L  = 3;
    localparam int TW = 16;

    logic            clk_core = 1'b0;
    logic            clk_core_reset;
    logic [L*8-1:0]  s_axis_tdata, s_axis_tdest;
    logic [L-1:0]    s_axis_tlast, s_axis_tvalid, s_axis_tready;
    logic [7:0]      m_axis_tdata, m_axis_tdest;
    logic            m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic [L-1:0]    cfg_layer_mask;
    logic [TW-1:0]   cfg_stall_timeout;
    logic            status_grant_active;
    logic [2:0]      status_grant_index;
    logic            stat_frame_done, stat_timeout;

    always #5 clk_core = ~clk_core;

    layers_frames_arbiter #(.LAYERS(L), .TIMEOUT_W(TW)) dut (
        .clk_core            (clk_core),
        .clk_core_reset      (clk_core_reset),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tdest        (s_axis_tdest),
        .s_axis_tlast        (s_axis_tlast),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tready       (s_axis_tready),
        .m_axis_tdata        (m_axis_tdata),
        .m_axis_tdest        (m_axis_tdest),
        .m_axis_tlast        (m_axis_tlast),
        .m_axis_tvalid       (m_axis_tvalid),
        .m_axis_tready       (m_axis_tready),
        .cfg_layer_mask      (cfg_layer_mask),
        .cfg_stall_timeout   (cfg_stall_timeout),
        .status_grant_active (status_grant_active),
        .status_grant_index  (status_grant_index),
        .stat_frame_done     (stat_frame_done),
        .stat_timeout        (stat_timeout)
    );

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic [7:0] dest;
        logic       l;
    } beat_t;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] dest;
        logic       l;
    } out_t;

    beat_t src_q[L][$];
    out_t  exp_q[$];

    int   total  = 0;
    int   bad    = 0;
    int   fd_cnt = 0;
    int   to_cnt = 0;
    logic toggle_ready = 1'b0;
    logic [L-1:0] adv    = '0;
    logic [L-1:0] driven = '0;

    // Source driver: drive on negedge, note handshakes just before posedge.
    initial begin
        beat_t b;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tdest  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        forever begin
            @(negedge clk_core);
            for (int i = 0; i < L; i++) begin
                if (adv[i]) begin
                    b = src_q[i].pop_front();
                end
                if (src_q[i].size() > 0) begin
                    b = src_q[i][0];
                    driven[i]            = 1'b1;
                    s_axis_tvalid[i]     = b.v;
                    s_axis_tdata[i*8+:8] = b.v ? b.d : 8'h00;
                    s_axis_tdest[i*8+:8] = b.v ? b.dest : 8'h00;
                    s_axis_tlast[i]      = b.v ? b.l : 1'b0;
                end else begin
                    driven[i]            = 1'b0;
                    s_axis_tvalid[i]     = 1'b0;
                    s_axis_tdata[i*8+:8] = 8'h00;
                    s_axis_tdest[i*8+:8] = 8'h00;
                    s_axis_tlast[i]      = 1'b0;
                end
            end
            m_axis_tready = toggle_ready ? ~m_axis_tready : 1'b1;
            #4;
            for (int i = 0; i < L; i++) begin
                if (driven[i]) begin
                    b      = src_q[i][0];
                    adv[i] = !b.v || s_axis_tready[i];
                end else begin
                    adv[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        logic prev_stall;
        out_t prev_o, e, got;
        prev_stall = 1'b0;
        prev_o     = '0;
        forever begin
            @(negedge clk_core);
            #4;
            if (stat_frame_done) fd_cnt++;
            if (stat_timeout) to_cnt++;
            got = {m_axis_tdata, m_axis_tdest, m_axis_tlast};
            if (prev_stall) begin
                total++;
                if (!m_axis_tvalid || got != prev_o) begin
                    bad++;
                    $display("FAIL stable_hold: got v=%0b %h/%h/%0b want v=1 %h/%h/%0b",
                             m_axis_tvalid, got.d, got.dest, got.l, prev_o.d, prev_o.dest, prev_o.l);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out: got %h dest %h last %0b want nothing", got.d, got.dest, got.l);
                end else begin
                    e = exp_q.pop_front();
                    if (got != e) begin
                        bad++;
                        $display("FAIL out_beat: got %h dest %h last %0b want %h dest %h last %0b",
                                 got.d, got.dest, got.l, e.d, e.dest, e.l);
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_o     = got;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    task automatic push_beat(input int ly, input logic v, input logic [7:0] d, input logic [7:0] dest, input logic l);
        beat_t b;
        b.v = v; b.d = d; b.dest = dest; b.l = l;
        src_q[ly].push_back(b);
    endtask

    task automatic push_frame(input int ly, input logic [7:0] d0, input int n, input logic [7:0] dest, input logic with_last);
        for (int k = 0; k < n; k++) begin
            push_beat(ly, 1'b1, d0 + 8'(k), dest, with_last && (k == n - 1));
        end
    endtask

    task automatic push_idle(input int ly, input int n);
        for (int k = 0; k < n; k++) begin
            push_beat(ly, 1'b0, 8'h00, 8'h00, 1'b0);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [7:0] dest, input logic l);
        out_t o;
        o.d = d; o.dest = dest; o.l = l;
        exp_q.push_back(o);
    endtask

    task automatic push_exp_frame(input logic [7:0] d0, input int n, input logic [7:0] dest);
        for (int k = 0; k < n; k++) begin
            push_exp(d0 + 8'(k), dest, k == n - 1);
        end
    endtask

    // Wait until all expected output is seen and the listed sources are empty.
    task automatic wait_done(input string name, input int budget, input logic [L-1:0] ign);
        int  c;
        logic done;
        c    = 0;
        done = 1'b0;
        while (c < budget) begin
            @(posedge clk_core);
            #1;
            done = (exp_q.size() == 0);
            for (int i = 0; i < L; i++) begin
                if (!ign[i] && src_q[i].size() != 0) done = 1'b0;
            end
            if (done) break;
            c++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_wait: got %0d beats pending want 0", name, exp_q.size());
        end
        repeat (4) @(posedge clk_core);
    endtask

    task automatic wait_grant(input string name, input logic [2:0] idx);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk_core);
            #1;
            seen = status_grant_active && (status_grant_index == idx);
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: got no grant want layer %0d", name, idx);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0, to0;
        logic seen;
        clk_core_reset    = 1'b1;
        cfg_layer_mask    = '0;
        cfg_stall_timeout = '0;
        repeat (3) @(posedge clk_core);
        #1;
        clk_core_reset = 1'b0;
        @(negedge clk_core);
        #2;
        chk("reset_tready", 32'(s_axis_tready), 0);
        chk("reset_m_tvalid", 32'(m_axis_tvalid), 0);
        chk("reset_m_tdata", 32'(m_axis_tdata), 0);
        chk("reset_m_tdest", 32'(m_axis_tdest), 0);
        chk("reset_m_tlast", 32'(m_axis_tlast), 0);
        chk("reset_grant_active", 32'(status_grant_active), 0);
        chk("reset_grant_index", 32'(status_grant_index), 0);
        chk("reset_frame_done", 32'(stat_frame_done), 0);
        chk("reset_timeout", 32'(stat_timeout), 0);

        // Round robin: two 4-byte frames queued on every layer.
        fd0 = fd_cnt;
        for (int ly = 0; ly < L; ly++) begin
            push_frame(ly, 8'(ly * 16), 4, 8'hA0 + 8'(ly), 1'b1);
            push_frame(ly, 8'(ly * 16 + 4), 4, 8'hA0 + 8'(ly), 1'b1);
        end
        push_exp_frame(8'h00, 4, 8'hA0);
        push_exp_frame(8'h10, 4, 8'hA1);
        push_exp_frame(8'h20, 4, 8'hA2);
        push_exp_frame(8'h04, 4, 8'hA0);
        push_exp_frame(8'h14, 4, 8'hA1);
        push_exp_frame(8'h24, 4, 8'hA2);
        wait_done("rr", 300, '0);
        chk("rr_frame_done", 32'(fd_cnt - fd0), 6);

        // Backpressure: sink ready toggles during a 5-byte frame.
        fd0 = fd_cnt;
        toggle_ready = 1'b1;
        push_frame(1, 8'h51, 5, 8'hB1, 1'b1);
        push_exp_frame(8'h51, 5, 8'hB1);
        wait_done("bp", 200, '0);
        toggle_ready = 1'b0;
        chk("bp_frame_done", 32'(fd_cnt - fd0), 1);

        // Stall timeout: 2 bytes, 20 idle cycles, 3 late bytes to be drained.
        cfg_stall_timeout = 16'd10;
        fd0 = fd_cnt;
        to0 = to_cnt;
        push_frame(2, 8'h21, 2, 8'hC2, 1'b0);
        push_idle(2, 20);
        push_frame(2, 8'h23, 3, 8'hC2, 1'b1);
        push_exp(8'h21, 8'hC2, 1'b0);
        push_exp(8'h22, 8'hC2, 1'b0);
        push_exp(8'hFF, 8'hC2, 1'b1);
        wait_done("timeout", 300, '0);
        chk("timeout_pulses", 32'(to_cnt - to0), 1);
        chk("timeout_frame_done", 32'(fd_cnt - fd0), 1);
        chk("drain_back_idle", 32'(status_grant_active), 0);

        // Mask: layer 1 excluded while all three layers offer frames.
        cfg_layer_mask = 3'b010;
        push_frame(0, 8'h01, 3, 8'hA0, 1'b1);
        push_frame(1, 8'h11, 3, 8'hA1, 1'b1);
        push_frame(2, 8'h31, 3, 8'hA2, 1'b1);
        push_exp_frame(8'h01, 3, 8'hA0);
        push_exp_frame(8'h31, 3, 8'hA2);
        wait_done("mask", 200, 3'b010);
        chk("mask_l1_pending", 32'(src_q[1].size()), 3);

        // Masking layer 0 mid-frame must let that frame finish.
        push_frame(0, 8'h41, 6, 8'hA0, 1'b1);
        push_exp_frame(8'h41, 6, 8'hA0);
        wait_grant("mask_mid_grant", 3'd0);
        cfg_layer_mask = 3'b011;
        wait_done("mask_mid", 200, 3'b010);
        chk("mask_mid_l1_pending", 32'(src_q[1].size()), 3);
        push_exp_frame(8'h11, 3, 8'hA1);
        cfg_layer_mask = 3'b000;
        wait_done("unmask", 200, '0);

        // Tie: tlast arrives exactly when the stall counter reaches 10.
        fd0 = fd_cnt;
        to0 = to_cnt;
        push_frame(0, 8'h61, 1, 8'hE0, 1'b0);
        push_idle(0, 10);
        push_frame(0, 8'h62, 1, 8'hE0, 1'b1);
        push_exp(8'h61, 8'hE0, 1'b0);
        push_exp(8'h62, 8'hE0, 1'b1);
        wait_done("tie", 200, '0);
        chk("tie_timeout", 32'(to_cnt - to0), 0);
        chk("tie_frame_done", 32'(fd_cnt - fd0), 1);

        // Reset mid-frame while byte 3 of a layer-0 frame is offered.
        cfg_stall_timeout = '0;
        push_frame(0, 8'h71, 5, 8'hD0, 1'b1);
        push_exp(8'h71, 8'hD0, 1'b0);
        push_exp(8'h72, 8'hD0, 1'b0);
        wait_grant("rst_first_grant", 3'd0);
        push_frame(1, 8'h81, 2, 8'hD1, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk_core);
            #2;
            seen = m_axis_tvalid && (m_axis_tdata == 8'h72);
        end
        chk("rst_byte2_seen", 32'(seen), 1);
        clk_core_reset = 1'b1;
        @(negedge clk_core);
        #2;
        clk_core_reset = 1'b0;
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 0);
        chk("rst_tready", 32'(s_axis_tready), 0);
        chk("rst_grant_active", 32'(status_grant_active), 0);
        push_exp(8'h73, 8'hD0, 1'b0);
        push_exp(8'h74, 8'hD0, 1'b0);
        push_exp(8'h75, 8'hD0, 1'b1);
        push_exp_frame(8'h81, 2, 8'hD1);
        @(posedge clk_core);
        #1;
        chk("rst_regrant_active", 32'(status_grant_active), 1);
        chk("rst_regrant_index", 32'(status_grant_index), 0);
        wait_done("reset", 200, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/layers_frames_arbiter.md
# layers_frames_arbiter

Merges frame byte streams from several layer interfaces into the single core-domain frame stream toward the readout buffer. It lives in `clk_core`, downstream of each layer interface's `frames_m_axis_*` port. It grants one layer at a time with round-robin priority and holds the grant until that layer's `tlast`. It protects the shared output against a stalled layer by forcing a timeout terminator and draining the rest of that layer's frame.

## Interface
Parameters:
- `LAYERS`, 3: number of layer inputs (1..8).
- `TIMEOUT_W`, 16: width of the stall-timeout counter.

Ports:
- `clk_core`  in  1: core clock; the only clock.
- `clk_core_reset`  in  1: reset, synchronous, active-high.
- `s_axis_tdata`  in  LAYERS×8: per-layer frame bytes.
- `s_axis_tdest`  in  LAYERS×8: per-layer tdest, passed through unchanged.
- `s_axis_tlast`  in  LAYERS: per-layer end of frame.
- `s_axis_tvalid`  in  LAYERS: per-layer valid.
- `s_axis_tready`  out  LAYERS: per-layer ready.
- `m_axis_tdata`  out  8: merged frame bytes.
- `m_axis_tdest`  out  8: tdest of the current byte.
- `m_axis_tlast`  out  1: end of frame on the output.
- `m_axis_tvalid`  out  1: output valid.
- `m_axis_tready`  in  1: output ready.
- `cfg_layer_mask`  in  LAYERS: 1 = layer excluded from arbitration.
- `cfg_stall_timeout`  in  TIMEOUT_W: idle cycles allowed mid-frame; 0 disables the timeout.
- `status_grant_active`  out  1: a frame is in progress.
- `status_grant_index`  out  3: index of the granted layer.
- `stat_frame_done`  out  1: 1-cycle pulse per completed frame, including timeout-terminated frames.
- `stat_timeout`  out  1: 1-cycle pulse when a timeout fires.

## Operation
- FSM states: IDLE, FORWARD, TERM, DRAIN.
- IDLE:
  - Candidates are layers with `tvalid & !mask`.
  - Pick the first candidate after `last_grant`, searching in rotation; this is round-robin.
  - Register `grant` and `last_grant`, then move to FORWARD.
  - In IDLE, no input sees `tready`.
- FORWARD:
  - `s_axis_tready[g] = (!m_axis_tvalid | m_axis_tready)`; every other input has ready 0.
  - The accepted byte, tdest and tlast load the output register.
  - On an accepted `tlast`: pulse `stat_frame_done` and go to IDLE.
  - Masking a layer mid-frame does not revoke its grant; the frame completes.
- Timeout:
  - In FORWARD, the stall counter increments on each cycle where `s_axis_tvalid[g]==0`.
  - It clears on every accepted byte.
  - It saturates rather than wrapping.
  - When the counter reaches `cfg_stall_timeout` and that value is nonzero: pulse `stat_timeout` and go to TERM.
- TERM:
  - When the output register is free, load the terminator: tdata 0xFF, tdest = last forwarded tdest, tlast 1.
  - Pulse `stat_frame_done` and go to DRAIN.
- DRAIN:
  - `s_axis_tready[g]=1`; accepted bytes are discarded.
  - On an accepted `tlast`, go to IDLE.
  - If the layer becomes masked, go to IDLE immediately.
- Output register:
  - `m_axis_tvalid` holds until `m_axis_tready`.
  - The data fields stay stable while valid and not ready.
- Simultaneous events: if a layer's `tlast` and the timeout occur in the same cycle, the `tlast` wins; no terminator is emitted.
- Reset mid-operation:
  - All state clears: `m_axis_tvalid` drops and any partially forwarded frame is abandoned.
  - `last_grant` resets to LAYERS-1, so layer 0 has first priority.

## Timing
- Reset values: all `s_axis_tready` 0, `m_axis_tvalid` 0, `m_axis_tdata/tdest/tlast` 0, `status_*` 0, `stat_*` 0, state IDLE.
- Arbitration latency: valid seen in IDLE at cycle N gives grant at N+1. The first byte can be accepted at N+1 and appears on `m_axis` at N+2.
- Throughput: 1 byte/cycle while the source is valid and the sink is ready. There is no bubble inside a frame.
- Frame-to-frame gap: 1 idle cycle on the inputs, for the IDLE re-arbitration.
- Stall counter: compares against `cfg_stall_timeout` in the same cycle; TERM is entered the cycle after the match.

## Structure
- Shared package `layers_pkg`:
  - state enum `arb_state_t`;
  - constant `FRAME_TERM_BYTE = 8'hFF`;
  - round-robin helper function `rr_next(req, last)`.
- One natural sub-module: `axis_out_reg`, the 1-deep registered AXIS stage with a load/free interface.
- Everything else stays inline.

## Test plan
- Round-robin fairness: LAYERS=3, all layers continuously offer 4-byte frames, sink always ready → output frame order is 0,1,2,0,1,2; no byte interleaving between frames; `stat_frame_done` count = 6 after 6 frames.
- Backpressure: `m_axis_tready` toggles 1/0 each cycle during a 5-byte frame from layer 1 → all 5 bytes are delivered in order, data stays stable while stalled, and `tlast` is set on the 5th byte only.
- Timeout: `cfg_stall_timeout=10`; layer 2 sends 2 bytes, then drops tvalid for 20 cycles, then sends 3 bytes with `tlast` → output is byte, byte, 0xFF with `tlast`. `stat_timeout` pulses once, and the 3 late bytes are drained and never reach the output.
- Mask: `cfg_layer_mask=3'b010`, all layers valid → layer 1 is never granted. Setting the mask bit for layer 0 mid-frame lets layer 0's frame finish intact.
- Tie, `tlast` vs timeout: the `tlast` arrives on the cycle where the counter hits the timeout → no 0xFF is emitted, no `stat_timeout` pulse, one `stat_frame_done` pulse.
- Reset mid-frame: assert `clk_core_reset` for 1 cycle during byte 3 of a frame from layer 0 → the next cycle shows `m_axis_tvalid=0` and all readies 0; the next grant goes to layer 0.
